// File: rtl/arb_merge2_sync.sv
// Two-input round-robin arbiter merging drive/free token streams into one
// credit-limited drive/free stream with a one-hot source select.
module arb_merge2_sync #(
  parameter int CREDITS = 2,
  parameter int CW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_drive_2,
  output logic [1:0] o_free_2,
  output logic       o_driveNext,
  input  logic       i_freeNext,
  output logic [1:0] o_sel_2,
  output logic       o_err
);

  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

  logic [1:0]    pend;
  logic [CW-1:0] credit;
  logic          last_gnt;
  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          any_gnt;
  logic          credit_full;
  logic          credit_inc;
  logic          err_set;
  logic [1:0]    pend_nxt;
  logic [CW-1:0] credit_nxt;

  always_comb begin
    req = pend & {2{credit != '0}};
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // last_gnt holds the index of the source granted most recently
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    any_gnt     = |gnt;
    credit_full = (credit == CREDIT_MAX);
    // A free at full credit is only legal when a grant consumes one the same cycle
    credit_inc  = i_freeNext & ~(credit_full & ~any_gnt);
    err_set     = (i_freeNext & credit_full & ~any_gnt)
                | (|(i_drive_2 & pend & ~gnt));
    pend_nxt    = (pend & ~gnt) | i_drive_2;
    credit_nxt  = credit;
    case ({credit_inc, any_gnt})
      2'b10:   credit_nxt = credit + 1'b1;
      2'b01:   credit_nxt = credit - 1'b1;
      default: credit_nxt = credit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend        <= 2'b00;
      credit      <= CREDIT_MAX;
      last_gnt    <= 1'b1;
      o_driveNext <= 1'b0;
      o_sel_2     <= 2'b00;
      o_free_2    <= 2'b00;
      o_err       <= 1'b0;
    end else begin
      pend        <= pend_nxt;
      credit      <= credit_nxt;
      if (any_gnt) last_gnt <= gnt[1];
      o_driveNext <= any_gnt;
      o_sel_2     <= gnt;
      o_free_2    <= gnt;
      o_err       <= o_err | err_set;
    end
  end

endmodule

// File: tb/tb_arb_merge2_sync.sv
// Directed bench for arb_merge2_sync: inputs change and outputs are sampled on
// the falling edge, one task per scenario.
module tb_arb_merge2_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] i_drive_2 = 2'b00;
  logic [1:0] o_free_2;
  logic       o_driveNext;
  logic       i_freeNext = 1'b0;
  logic [1:0] o_sel_2;
  logic       o_err;

  int n_checks = 0;
  int n_errors = 0;

  arb_merge2_sync #(.CREDITS(2), .CW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_drive_2  (i_drive_2),
    .o_free_2   (o_free_2),
    .o_driveNext(o_driveNext),
    .i_freeNext (i_freeNext),
    .o_sel_2    (o_sel_2),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; i_drive_2 = 2'b00; i_freeNext = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // {o_driveNext, o_sel_2, o_free_2}
  function automatic logic [4:0] outv();
    return {o_driveNext, o_sel_2, o_free_2};
  endfunction

  function automatic logic [4:0] pulse(input logic [1:0] s);
    return (s == 2'b00) ? 5'b00000 : {1'b1, s, s};
  endfunction

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (outv() !== 5'b00000) begin
      n_errors++; $display("FAIL reset_out got %b exp %b", outv(), 5'b00000);
    end
    n_checks++;
    if (o_err !== 1'b0) begin
      n_errors++; $display("FAIL reset_err got %b exp 0", o_err);
    end
    n_checks++;
    if (dut.credit !== 4'd2) begin
      n_errors++; $display("FAIL reset_credit got %0d exp 2", dut.credit);
    end
  endtask

  task automatic test_single();
    do_reset();
    i_drive_2 = 2'b01;
    tick(); i_drive_2 = 2'b00;
    n_checks++;
    if (outv() !== 5'b00000) begin
      n_errors++; $display("FAIL single_early got %b exp %b", outv(), 5'b00000);
    end
    tick();
    n_checks++;
    if (outv() !== pulse(2'b01)) begin
      n_errors++; $display("FAIL single_pulse got %b exp %b", outv(), pulse(2'b01));
    end
    tick();
    n_checks++;
    if (outv() !== 5'b00000) begin
      n_errors++; $display("FAIL single_after got %b exp %b", outv(), 5'b00000);
    end
    n_checks++;
    if (dut.credit !== 4'd1) begin
      n_errors++; $display("FAIL single_credit got %0d exp 1", dut.credit);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] drv [0:8] = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    logic       fre [0:8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] exs [0:8] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    do_reset();
    for (int c = 0; c < 9; c++) begin
      n_checks++;
      if (outv() !== pulse(exs[c])) begin
        n_errors++; $display("FAIL fair_c%0d got %b exp %b", c, outv(), pulse(exs[c]));
      end
      i_drive_2 = drv[c]; i_freeNext = fre[c];
      tick();
    end
    i_drive_2 = 2'b00; i_freeNext = 1'b0;
    n_checks++;
    if (o_err !== 1'b0 || dut.credit !== 4'd2) begin
      n_errors++; $display("FAIL fair_end got err=%b credit=%0d exp err=0 credit=2", o_err, dut.credit);
    end
  endtask

  task automatic test_credit_exhaust();
    int pulses = 0;
    do_reset();
    i_drive_2 = 2'b01;
    tick(); i_drive_2 = 2'b00;
    tick();
    if (o_driveNext) pulses++;
    n_checks++;
    if (outv() !== pulse(2'b01)) begin
      n_errors++; $display("FAIL exh_p1 got %b exp %b", outv(), pulse(2'b01));
    end
    i_drive_2 = 2'b01;
    tick(); i_drive_2 = 2'b00;
    tick();
    if (o_driveNext) pulses++;
    n_checks++;
    if (outv() !== pulse(2'b01)) begin
      n_errors++; $display("FAIL exh_p2 got %b exp %b", outv(), pulse(2'b01));
    end
    i_drive_2 = 2'b01;
    tick(); i_drive_2 = 2'b00;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_driveNext) pulses++;
    end
    n_checks++;
    if (pulses != 2 || dut.credit !== 4'd0) begin
      n_errors++; $display("FAIL exh_block got pulses=%0d credit=%0d exp pulses=2 credit=0", pulses, dut.credit);
    end
    i_freeNext = 1'b1;
    tick(); i_freeNext = 1'b0;
    n_checks++;
    if (outv() !== 5'b00000) begin
      n_errors++; $display("FAIL exh_p3_early got %b exp %b", outv(), 5'b00000);
    end
    tick();
    if (o_driveNext) pulses++;
    n_checks++;
    if (outv() !== pulse(2'b01)) begin
      n_errors++; $display("FAIL exh_p3 got %b exp %b", outv(), pulse(2'b01));
    end
    i_drive_2 = 2'b01;
    tick(); i_drive_2 = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_driveNext) pulses++;
    end
    i_freeNext = 1'b1;
    tick(); i_freeNext = 1'b0;
    tick();
    if (o_driveNext) pulses++;
    n_checks++;
    if (outv() !== pulse(2'b01) || pulses != 4) begin
      n_errors++; $display("FAIL exh_p4 got %b pulses=%0d exp %b pulses=4", outv(), pulses, pulse(2'b01));
    end
  endtask

  task automatic test_same_cycle_credit();
    do_reset();
    i_drive_2 = 2'b01;
    tick(); i_drive_2 = 2'b00;
    tick();
    i_drive_2 = 2'b11;
    tick(); i_drive_2 = 2'b00; i_freeNext = 1'b1;
    tick(); i_freeNext = 1'b0;
    n_checks++;
    if (outv() !== pulse(2'b10) || dut.credit !== 4'd1) begin
      n_errors++; $display("FAIL same_g1 got %b credit=%0d exp %b credit=1", outv(), dut.credit, pulse(2'b10));
    end
    tick();
    n_checks++;
    if (outv() !== pulse(2'b01) || dut.credit !== 4'd0) begin
      n_errors++; $display("FAIL same_g2 got %b credit=%0d exp %b credit=0", outv(), dut.credit, pulse(2'b01));
    end
  endtask

  task automatic test_overflow();
    int pulses = 0;
    do_reset();
    i_drive_2 = 2'b11;
    tick(); i_drive_2 = 2'b00;
    tick();
    tick();
    n_checks++;
    if (outv() !== pulse(2'b10) || dut.credit !== 4'd0) begin
      n_errors++; $display("FAIL ovf_drain got %b credit=%0d exp %b credit=0", outv(), dut.credit, pulse(2'b10));
    end
    i_drive_2 = 2'b01;
    tick(); i_drive_2 = 2'b00;
    n_checks++;
    if (o_err !== 1'b0) begin
      n_errors++; $display("FAIL ovf_pre_err got %b exp 0", o_err);
    end
    tick(); i_drive_2 = 2'b01;
    tick(); i_drive_2 = 2'b00;
    n_checks++;
    if (o_err !== 1'b1) begin
      n_errors++; $display("FAIL ovf_err got %b exp 1", o_err);
    end
    i_freeNext = 1'b1;
    tick(); i_freeNext = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_driveNext) pulses++;
    end
    n_checks++;
    if (pulses != 1 || o_err !== 1'b1) begin
      n_errors++; $display("FAIL ovf_count got pulses=%0d err=%b exp pulses=1 err=1", pulses, o_err);
    end

    do_reset();
    i_freeNext = 1'b1;
    tick(); i_freeNext = 1'b0;
    n_checks++;
    if (o_err !== 1'b1 || dut.credit !== 4'd2) begin
      n_errors++; $display("FAIL full_free got err=%b credit=%0d exp err=1 credit=2", o_err, dut.credit);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    i_drive_2 = 2'b11;
    tick(); i_drive_2 = 2'b00;
    tick();
    tick(); i_drive_2 = 2'b11;
    tick(); i_drive_2 = 2'b00;
    n_checks++;
    if (dut.pend !== 2'b11 || dut.credit !== 4'd0) begin
      n_errors++; $display("FAIL mid_setup got pend=%b credit=%0d exp pend=11 credit=0", dut.pend, dut.credit);
    end
    rst = 1'b1;
    tick(); rst = 1'b0; i_drive_2 = 2'b10;
    n_checks++;
    if (outv() !== 5'b00000 || o_err !== 1'b0 || dut.credit !== 4'd2) begin
      n_errors++; $display("FAIL mid_rst got out=%b err=%b credit=%0d exp out=00000 err=0 credit=2", outv(), o_err, dut.credit);
    end
    tick(); i_drive_2 = 2'b00;
    n_checks++;
    if (outv() !== 5'b00000) begin
      n_errors++; $display("FAIL mid_quiet got %b exp %b", outv(), 5'b00000);
    end
    tick();
    n_checks++;
    if (outv() !== pulse(2'b10) || o_err !== 1'b0) begin
      n_errors++; $display("FAIL mid_fwd got %b err=%b exp %b err=0", outv(), o_err, pulse(2'b10));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_credit_exhaust();
    test_same_cycle_credit();
    test_overflow();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
